// File: rtl/seq_alu_responder_if.sv
// ---------------------------------------------------------------------------
// seq_alu_responder_if
//   Request/response channel bundle for the sequential arithmetic responder.
//   master : the operation issuer (drives requests, accepts responses)
//   slave  : the responder        (accepts requests, drives responses)
//
//   req_valid/req_ready   request handshake
//   req_a, req_b          operands (A = multiplicand/dividend, B = multiplier/divisor)
//   req_opcode            00 ADD, 01 SUB, 10 DIV, 11 MUL
//   rsp_valid/rsp_ready   response handshake
//   rsp_result            sum / difference / quotient / low product half
//   rsp_carry             ADD carry, SUB borrow, MUL high half nonzero, 0 for DIV
//   rsp_dz                divide by zero
// ---------------------------------------------------------------------------
interface seq_alu_responder_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [1:0]       req_opcode;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_dz;

  modport master (
    output req_valid, req_a, req_b, req_opcode, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_dz
  );

  modport slave (
    input  req_valid, req_a, req_b, req_opcode, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_dz
  );
endinterface

// File: rtl/seq_alu_responder.sv
// ---------------------------------------------------------------------------
// seq_alu_responder
//   Handshaked arithmetic responder. ADD/SUB complete in one cycle; MUL
//   (shift-add) and DIV (restoring) iterate one bit per cycle for WIDTH
//   cycles. One operation in flight at a time; the response is held until
//   the consumer takes it.
//
//   clk   system clock, rising edge
//   rst   asynchronous, active-low reset
//   bus   request/response channel (slave side of seq_alu_responder_if)
// ---------------------------------------------------------------------------
module seq_alu_responder #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_alu_responder_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_DIV = 2'b10,
    OP_MUL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_e;

  state_e           r_state;
  state_e           w_state_next;
  op_e              r_op;
  op_e              w_req_op;

  // r_hi/r_lo form the 2*WIDTH working register: product {hi,lo} for MUL,
  // {remainder, dividend/quotient} for DIV. r_d holds multiplicand/divisor.
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_dz;

  logic             w_accept;
  logic             w_multi_cycle;
  logic             w_last_iter;
  logic [WIDTH:0]   w_add_sum;
  logic [WIDTH:0]   w_sub_diff;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  assign w_req_op      = op_e'(bus.req_opcode);
  assign w_accept      = bus.req_valid && (r_state == ST_IDLE);
  // DIV by zero short-circuits straight to the response.
  assign w_multi_cycle = (w_req_op == OP_MUL) ||
                         ((w_req_op == OP_DIV) && (bus.req_b != '0));
  assign w_last_iter   = (r_cnt == CNT_W'(WIDTH - 1));

  // Single-cycle arithmetic, one extra bit to capture carry / borrow.
  assign w_add_sum  = {1'b0, bus.req_a} + {1'b0, bus.req_b};
  assign w_sub_diff = {1'b0, bus.req_a} - {1'b0, bus.req_b};

  // One MUL or DIV iteration.
  // MUL: conditionally add multiplicand into the high half, then shift the
  //      whole {carry, hi, lo} right by one.
  // DIV: shift the next dividend bit into the partial remainder; subtract
  //      the divisor if it fits and record a quotient bit of 1.
  assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_d});

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_hi_next = r_hi;
    w_lo_next = r_lo;
    if (r_op == OP_MUL) begin
      w_hi_next = w_mul_sum[WIDTH:1];
      w_lo_next = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end else if (w_div_ge) begin
      // Partial remainder stays below the divisor, so the WIDTH-bit
      // difference is exact.
      w_hi_next = w_div_shift[WIDTH-1:0] - r_d;
      w_lo_next = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_hi_next = w_div_shift[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_state_next = w_multi_cycle ? ST_BUSY : ST_RESP;
        end
      end
      ST_BUSY: begin
        if (w_last_iter) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op     <= OP_ADD;
      r_hi     <= '0;
      r_lo     <= '0;
      r_d      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op  <= w_req_op;
            r_cnt <= '0;
            r_hi  <= '0;
            case (w_req_op)
              OP_ADD: begin
                r_result <= w_add_sum[WIDTH-1:0];
                r_carry  <= w_add_sum[WIDTH];
                r_dz     <= 1'b0;
              end
              OP_SUB: begin
                r_result <= w_sub_diff[WIDTH-1:0];
                r_carry  <= w_sub_diff[WIDTH];
                r_dz     <= 1'b0;
              end
              OP_DIV: begin
                if (bus.req_b == '0) begin
                  r_result <= '1;
                  r_carry  <= 1'b0;
                  r_dz     <= 1'b1;
                end else begin
                  r_lo <= bus.req_a;
                  r_d  <= bus.req_b;
                end
              end
              default: begin
                r_lo <= bus.req_b;
                r_d  <= bus.req_a;
              end
            endcase
          end
        end
        ST_BUSY: begin
          r_hi  <= w_hi_next;
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last_iter) begin
            r_result <= w_lo_next;
            r_carry  <= (r_op == OP_MUL) ? (|w_hi_next) : 1'b0;
            r_dz     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_result = r_result;
  assign bus.rsp_carry  = r_carry;
  assign bus.rsp_dz     = r_dz;

endmodule
